// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction-driven datapath controller:
// controller states, instruction field layout, opcode and ALU encodings.
package cpu_pkg;

    typedef enum logic [2:0] {
        WAIT,
        DECODE,
        WRITE_IMM,
        GET_A,
        GET_B,
        EXEC,
        WRITE_REG
    } state_t;

    typedef struct packed {
        logic [2:0] opcode;
        logic [1:0] op;
        logic [2:0] rn;
        logic [2:0] rd;
        logic [1:0] sh;
        logic [2:0] rm;
    } instr_t;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_MVN = 2'b11;

endpackage

// File: rtl/instr_dec.sv
// Splits the instruction register into its fields and sign-extends the
// 8-bit immediate; purely combinational.
module instr_dec
    import cpu_pkg::*;
(
    input  logic [15:0] ir,
    output instr_t      fields,
    output logic [15:0] sximm8
);

    assign fields.opcode = ir[15:13];
    assign fields.op     = ir[12:11];
    assign fields.rn     = ir[10:8];
    assign fields.rd     = ir[7:5];
    assign fields.sh     = ir[4:3];
    assign fields.rm     = ir[2:0];

    assign sximm8 = {{8{ir[7]}}, ir[7:0]};

endmodule

// File: rtl/datapath_fsm.sv
// Controller for a simple register-file datapath: holds the instruction
// register and sequences read, execute and writeback with Moore outputs.
module datapath_fsm
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        s,
    input  logic        load,
    input  logic [15:0] in,
    output logic        w,
    output logic [2:0]  r_addr,
    output logic [2:0]  w_addr,
    output logic        w_en,
    output logic        vsel,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] sximm8
);

    state_t      state;
    state_t      next_state;
    logic [15:0] ir;
    instr_t      f;

    logic is_mov_imm;
    logic is_mov_reg;
    logic is_add;
    logic is_cmp;
    logic is_and;
    logic is_mvn;

    instr_dec u_dec (
        .ir     (ir),
        .fields (f),
        .sximm8 (sximm8)
    );

    // The instruction register only accepts a new word while idle, so a
    // running instruction always sees stable fields.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir <= 16'h0000;
        end else if (load && state == WAIT) begin
            ir <= in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= WAIT;
        end else begin
            state <= next_state;
        end
    end

    assign is_mov_imm = (f.opcode == OPC_MOV) && (f.op == OP_MOV_IMM);
    assign is_mov_reg = (f.opcode == OPC_MOV) && (f.op == OP_MOV_REG);
    assign is_add     = (f.opcode == OPC_ALU) && (f.op == OP_ADD);
    assign is_cmp     = (f.opcode == OPC_ALU) && (f.op == OP_CMP);
    assign is_and     = (f.opcode == OPC_ALU) && (f.op == OP_AND);
    assign is_mvn     = (f.opcode == OPC_ALU) && (f.op == OP_MVN);

    // Single-operand instructions skip GET_A; CMP skips writeback.
    always_comb begin
        next_state = state;
        case (state)
            WAIT: begin
                if (s) next_state = DECODE;
            end
            DECODE: begin
                if (is_mov_imm)                  next_state = WRITE_IMM;
                else if (is_mov_reg || is_mvn)   next_state = GET_B;
                else if (is_add || is_and || is_cmp) next_state = GET_A;
                else                             next_state = WAIT;
            end
            WRITE_IMM: next_state = WAIT;
            GET_A:     next_state = GET_B;
            GET_B:     next_state = EXEC;
            EXEC:      next_state = is_cmp ? WAIT : WRITE_REG;
            WRITE_REG: next_state = WAIT;
            default:   next_state = WAIT;
        endcase
    end

    always_comb begin
        w      = 1'b0;
        r_addr = 3'd0;
        w_addr = 3'd0;
        w_en   = 1'b0;
        vsel   = 1'b0;
        loada  = 1'b0;
        loadb  = 1'b0;
        loadc  = 1'b0;
        loads  = 1'b0;
        asel   = 1'b0;
        shift  = 2'b00;
        ALUop  = ALU_ADD;
        case (state)
            WAIT: begin
                w = 1'b1;
            end
            WRITE_IMM: begin
                w_en   = 1'b1;
                w_addr = f.rn;
                vsel   = 1'b1;
            end
            GET_A: begin
                r_addr = f.rn;
                loada  = 1'b1;
            end
            GET_B: begin
                r_addr = f.rm;
                loadb  = 1'b1;
                shift  = f.sh;
            end
            // MOV reg reuses the adder with a zeroed A operand.
            EXEC: begin
                loadc = ~is_cmp;
                loads = is_cmp;
                ALUop = (f.opcode == OPC_ALU) ? f.op : ALU_ADD;
                asel  = is_mov_reg | is_mvn;
            end
            WRITE_REG: begin
                w_en   = 1'b1;
                w_addr = f.rd;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_datapath_fsm.sv
// Randomised scoreboard bench for datapath_fsm: a reference model turns each
// issued instruction into its expected per-cycle output trace.
module tb_datapath_fsm;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        s = 1'b0;
    logic        load = 1'b0;
    logic [15:0] in = 16'h0000;
    logic        w;
    logic [2:0]  r_addr;
    logic [2:0]  w_addr;
    logic        w_en;
    logic        vsel;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic [1:0]  shift;
    logic [1:0]  ALUop;
    logic [15:0] sximm8;

    typedef struct packed {
        logic        w;
        logic [2:0]  r_addr;
        logic [2:0]  w_addr;
        logic        w_en;
        logic        vsel;
        logic        loada;
        logic        loadb;
        logic        loadc;
        logic        loads;
        logic        asel;
        logic [1:0]  shift;
        logic [1:0]  alu_op;
        logic [15:0] sximm8;
    } obs_t;

    obs_t        exp_q[$];
    obs_t        mon_exp;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] ir_model = 16'h0000;

    datapath_fsm dut (
        .clk    (clk),
        .reset  (reset),
        .s      (s),
        .load   (load),
        .in     (in),
        .w      (w),
        .r_addr (r_addr),
        .w_addr (w_addr),
        .w_en   (w_en),
        .vsel   (vsel),
        .loada  (loada),
        .loadb  (loadb),
        .loadc  (loadc),
        .loads  (loads),
        .asel   (asel),
        .shift  (shift),
        .ALUop  (ALUop),
        .sximm8 (sximm8)
    );

    always #5 clk = ~clk;

    function automatic obs_t sample_dut();
        obs_t o;
        o.w      = w;
        o.r_addr = r_addr;
        o.w_addr = w_addr;
        o.w_en   = w_en;
        o.vsel   = vsel;
        o.loada  = loada;
        o.loadb  = loadb;
        o.loadc  = loadc;
        o.loads  = loads;
        o.asel   = asel;
        o.shift  = shift;
        o.alu_op = ALUop;
        o.sximm8 = sximm8;
        return o;
    endfunction

    function automatic obs_t reset_pattern();
        obs_t o = '0;
        o.w = 1'b1;
        return o;
    endfunction

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && exp_q.size() != 0) begin
            mon_exp = exp_q.pop_front();
            check_output("trace", 64'(sample_dut()), 64'(mon_exp));
        end
    end

    // Expected trace from DECODE through the return to WAIT, built from the
    // instruction's meaning; returns the edge count until w is high again.
    task automatic push_expected(input logic [15:0] ir, output int lat);
        logic [2:0]  opc = ir[15:13];
        logic [1:0]  op  = ir[12:11];
        logic [2:0]  rn  = ir[10:8];
        logic [2:0]  rd  = ir[7:5];
        logic [1:0]  sh  = ir[4:3];
        logic [2:0]  rm  = ir[2:0];
        logic [7:0]  imm8 = ir[7:0];
        obs_t        base = '0;
        obs_t        rec;
        bit mov_imm = (opc == 3'b110) && (op == 2'b10);
        bit mov_reg = (opc == 3'b110) && (op == 2'b00);
        bit two_op  = (opc == 3'b101) && (op != 2'b11);
        bit mvn     = (opc == 3'b101) && (op == 2'b11);
        bit cmp     = (opc == 3'b101) && (op == 2'b01);
        base.sximm8 = 16'($signed(imm8));
        exp_q.push_back(base);
        if (mov_imm) begin
            rec = base; rec.w_en = 1; rec.w_addr = rn; rec.vsel = 1;
            exp_q.push_back(rec);
            lat = 2;
        end else if (mov_reg || mvn || two_op) begin
            if (two_op) begin
                rec = base; rec.r_addr = rn; rec.loada = 1;
                exp_q.push_back(rec);
            end
            rec = base; rec.r_addr = rm; rec.loadb = 1; rec.shift = sh;
            exp_q.push_back(rec);
            rec = base;
            rec.loadc  = !cmp;
            rec.loads  = cmp;
            rec.alu_op = (opc == 3'b101) ? op : 2'b00;
            rec.asel   = mov_reg || mvn;
            exp_q.push_back(rec);
            if (!cmp) begin
                rec = base; rec.w_en = 1; rec.w_addr = rd;
                exp_q.push_back(rec);
            end
            lat = two_op ? (cmp ? 4 : 5) : 4;
        end else begin
            lat = 1;
        end
        rec = base; rec.w = 1;
        exp_q.push_back(rec);
    endtask

    // Called just after a rising edge while in WAIT; runs one instruction and
    // leaves the bench just after the edge that returns to WAIT.
    task automatic apply_stimulus(input logic [15:0] instr, input bit do_load);
        int lat;
        int n = 0;
        in   = instr;
        load = do_load;
        s    = 1'b1;
        if (do_load) ir_model = instr;
        @(posedge clk); #1;
        push_expected(ir_model, lat);
        while (!w && n < 20) begin
            load = 1'($urandom);
            in   = 16'($urandom);
            s    = 1'($urandom);
            @(posedge clk); #1;
            n++;
        end
        load = 1'b0;
        s    = 1'b0;
        check_output("latency", 64'(n), 64'(lat));
    endtask

    task automatic idle_cycle();
        load = 1'($urandom);
        in   = 16'($urandom);
        s    = 1'b0;
        if (load) ir_model = in;
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    function automatic logic [15:0] random_instr();
        logic [15:0] r = 16'($urandom);
        case ($urandom_range(0, 3))
            0, 1: r[15:13] = 3'b101;
            2:    r[15:13] = 3'b110;
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        #2;
        check_output("reset_outputs", 64'(sample_dut()), 64'(reset_pattern()));
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check_output("idle_after_reset", 64'(sample_dut()), 64'(reset_pattern()));

        apply_stimulus(16'hD007, 1'b1);
        apply_stimulus(16'hD1FE, 1'b1);
        apply_stimulus(16'hA148, 1'b1);
        apply_stimulus(16'hA900, 1'b1);
        apply_stimulus(16'h0000, 1'b1);
        apply_stimulus(16'hC0E3, 1'b1);
        apply_stimulus(16'hB8E5, 1'b1);
        apply_stimulus(16'hB0E5, 1'b0);

        // Abort an ADD while it is reading the B operand.
        in = 16'hA148; load = 1'b1; s = 1'b1; ir_model = 16'hA148;
        @(posedge clk); #1;
        load = 1'b0; s = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_output("getb_loadb", 64'(loadb), 64'd1);
        check_output("getb_raddr", 64'(r_addr), 64'd0);
        reset = 1'b1;
        exp_q.delete();
        ir_model = 16'h0000;
        #1;
        check_output("midreset_outputs", 64'(sample_dut()), 64'(reset_pattern()));
        @(posedge clk); #1;
        check_output("held_reset_outputs", 64'(sample_dut()), 64'(reset_pattern()));
        reset = 1'b0;
        @(posedge clk); #1;
        check_output("after_abort", 64'(sample_dut()), 64'(reset_pattern()));
        apply_stimulus(16'hD3AA, 1'b0);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 2) == 0) idle_cycle();
            apply_stimulus(random_instr(), $urandom_range(0, 4) != 0);
        end

        @(negedge clk); #1;
        check_output("scoreboard_drain", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
